// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]     INSTR_NOP = 32'h0000_0013;
  // Max in-flight imem requests; also the depth of the return buffer.
  localparam int              MAX_OUTST = 2;

  typedef enum logic [0:0] {
    RUN           = 1'b0,
    HALT_MISALIGN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO holding fetched {instr, pc} pairs for decode.
// Push into a full buffer or pop from an empty one is ignored.
module fetch_buffer import fetch_unit_pkg::*; #(
  parameter int DEPTH = MAX_OUTST,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer/occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage needs no reset; occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem requests under a credit
// limit, buffers returned words and hands {instr, pc, pc+4} to decode.
module fetch_unit import fetch_unit_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            if_misaligned
);

  localparam int OW = $clog2(MAX_OUTST + 1);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc, resp_pc;
  logic [OW-1:0]   outst, drop, outst_nxt, buf_count;
  logic [OW:0]     credit_used;
  logic            req_fire, buf_push, buf_pop, buf_full, buf_empty;
  fetch_entry_t    head, rsp_entry;

  // Outstanding requests plus buffered words may never exceed the buffer
  // depth, so every response is guaranteed a slot.
  assign credit_used    = {1'b0, outst} + {1'b0, buf_count};
  assign imem_req_valid = !rst && (state == RUN) && (credit_used < (OW+1)'(MAX_OUTST));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign outst_nxt      = outst - OW'(imem_rsp_valid) + OW'(req_fire);

  // Stale words (drop != 0) and words racing a redirect never enter the buffer.
  assign buf_push  = imem_rsp_valid && (drop == '0) && !redirect_valid && !rst;
  assign buf_pop   = if_valid && if_ready && !redirect_valid;
  assign rsp_entry = '{instr: imem_rsp_data, pc: resp_pc};

  fetch_buffer #(.DEPTH(MAX_OUTST)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .pop      (buf_pop),
    .flush    (redirect_valid),
    .wr_entry (rsp_entry),
    .head     (head),
    .count    (buf_count),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  assign if_valid      = !buf_empty;
  assign if_instr      = buf_empty ? INSTR_NOP : head.instr;
  assign if_pc         = buf_empty ? resp_pc   : head.pc;
  assign if_pc_plus4   = if_pc + XLEN'(4);
  assign if_misaligned = (state == HALT_MISALIGN);

  // PC, counters and FSM. Reset and redirect both abandon whatever is in
  // flight: outst keeps tracking it and drop marks it all as stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      outst    <= outst_nxt;
      drop     <= outst_nxt;
    end else if (redirect_valid) begin
      state    <= (redirect_pc[1:0] != 2'b00) ? HALT_MISALIGN : RUN;
      fetch_pc <= redirect_pc;
      resp_pc  <= redirect_pc;
      outst    <= outst_nxt;
      drop     <= outst_nxt;
    end else begin
      outst <= outst_nxt;
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (buf_push) resp_pc  <= resp_pc + XLEN'(4);
      if (imem_rsp_valid && (drop != '0)) drop <= drop - OW'(1);
    end
  end

  // Memory must only answer issued requests, and credits must keep a slot free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && (outst == '0)));
      assert (!(buf_push && buf_full));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order fixed-latency memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready, if_misaligned;
  logic [31:0] if_instr, if_pc, if_pc_plus4;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_misaligned  (if_misaligned)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int lat    = 1;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_pc[$], pop_instr[$], pop_pc4[$];

  // Values seen in the current cycle, sampled just before the active edge.
  logic        s_req_v, s_if_v, s_mis;
  logic [31:0] s_req_a, s_pc, s_instr, s_pc4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  // One clock: memory answers the oldest due request (data = ~addr),
  // outputs are sampled, then handshakes are logged at the edge.
  task automatic tick();
    logic rsp_v;
    rsp_v = (mq_due.size() > 0) && (mq_due[0] <= cyc);
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_v ? ~mq_addr[0] : 32'h0;
    #1;
    s_req_v = imem_req_valid; s_req_a = imem_req_addr;
    s_if_v  = if_valid;       s_pc    = if_pc;
    s_instr = if_instr;       s_pc4   = if_pc_plus4;
    s_mis   = if_misaligned;
    @(posedge clk);
    if (s_req_v && imem_req_ready) begin
      req_log.push_back(s_req_a);
      mq_addr.push_back(s_req_a);
      mq_due.push_back(cyc + lat);
    end
    if (rsp_v) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (s_if_v && if_ready && !redirect_valid) begin
      pop_pc.push_back(s_pc);
      pop_instr.push_back(s_instr);
      pop_pc4.push_back(s_pc4);
    end
    cyc++;
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete(); pop_pc.delete(); pop_instr.delete(); pop_pc4.delete();
  endtask

  // Let all in-flight responses return, then pulse reset from a quiet state.
  task automatic drain_reset();
    int n = 0;
    imem_req_ready = 1'b0;
    while (mq_due.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(mq_due.size()), 32'd0);
    imem_req_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;

    // Reset state
    tick();
    chk("rst_req_valid", 32'(s_req_v), 32'd0);
    tick();
    chk("rst_if_valid", 32'(s_if_v), 32'd0);
    chk("rst_if_instr", s_instr, 32'h0000_0013);
    chk("rst_if_pc", s_pc, 32'h0);
    chk("rst_misalign", 32'(s_mis), 32'd0);
    rst = 1'b0;
    clear_logs();

    // 1: latency 1, decode always ready
    tick();
    chk("t1_c0_req_valid", 32'(s_req_v), 32'd1);
    chk("t1_c0_req_addr", s_req_a, 32'h0);
    chk("t1_c0_if_valid", 32'(s_if_v), 32'd0);
    tick();
    chk("t1_c1_if_valid", 32'(s_if_v), 32'd0);
    chk("t1_c1_req_addr", s_req_a, 32'h4);
    tick();
    chk("t1_c2_if_valid", 32'(s_if_v), 32'd1);
    chk("t1_c2_if_pc", s_pc, 32'h0);
    repeat (12) tick();
    chk("t1_req2", qget(req_log, 2), 32'h8);
    chk("t1_req3", qget(req_log, 3), 32'hC);
    chk("t1_pop0", qget(pop_pc, 0), 32'h0);
    chk("t1_pop1", qget(pop_pc, 1), 32'h4);
    chk("t1_pop2", qget(pop_pc, 2), 32'h8);
    chk("t1_pop3", qget(pop_pc, 3), 32'hC);
    chk("t1_instr2", qget(pop_instr, 2), 32'hFFFF_FFF7);
    chk("t1_pc4_3", qget(pop_pc4, 3), 32'h10);

    // 2: decode stalls for 5 cycles
    drain_reset();
    if_ready = 1'b0;
    tick(); tick(); tick();
    chk("t2_c2_if_valid", 32'(s_if_v), 32'd1);
    chk("t2_c2_if_pc", s_pc, 32'h0);
    tick(); tick();
    chk("t2_c4_req_valid", 32'(s_req_v), 32'd0);
    chk("t2_c4_if_pc", s_pc, 32'h0);
    chk("t2_c4_if_instr", s_instr, 32'hFFFF_FFFF);
    chk("t2_nreq", 32'(req_log.size()), 32'd2);
    if_ready = 1'b1;
    repeat (12) tick();
    chk("t2_pop0", qget(pop_pc, 0), 32'h0);
    chk("t2_pop1", qget(pop_pc, 1), 32'h4);
    chk("t2_pop2", qget(pop_pc, 2), 32'h8);

    // 3: latency 2, redirect together with a response
    drain_reset();
    lat = 2;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("t3_req_valid", 32'(s_req_v), 32'd1);
    chk("t3_req_addr", s_req_a, 32'h100);
    chk("t3_if_valid", 32'(s_if_v), 32'd0);
    repeat (12) tick();
    chk("t3_pop0", qget(pop_pc, 0), 32'h100);
    chk("t3_pop1", qget(pop_pc, 1), 32'h104);
    chk("t3_instr0", qget(pop_instr, 0), 32'hFFFF_FEFF);
    chk("t3_pc4_0", qget(pop_pc4, 0), 32'h104);

    // 4: misaligned redirect halts, aligned redirect resumes
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("t4_mis", 32'(s_mis), 32'd1);
    chk("t4_req_valid", 32'(s_req_v), 32'd0);
    chk("t4_if_valid", 32'(s_if_v), 32'd0);
    repeat (4) tick();
    chk("t4_mis_late", 32'(s_mis), 32'd1);
    chk("t4_req_valid_late", 32'(s_req_v), 32'd0);
    chk("t4_if_valid_late", 32'(s_if_v), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    clear_logs();
    imem_req_ready = 1'b0;
    tick();
    chk("t4_resume_mis", 32'(s_mis), 32'd0);
    chk("t4_resume_req", 32'(s_req_v), 32'd1);
    chk("t4_resume_addr", s_req_a, 32'h200);
    tick();
    chk("t4_hold_req", 32'(s_req_v), 32'd1);
    chk("t4_hold_addr", s_req_a, 32'h200);
    imem_req_ready = 1'b1;
    repeat (12) tick();
    chk("t4_pop0", qget(pop_pc, 0), 32'h200);
    chk("t4_pop1", qget(pop_pc, 1), 32'h204);

    // 5: reset with two requests in flight
    drain_reset();
    lat = 2;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_req_valid", 32'(s_req_v), 32'd0);
    rst = 1'b0;
    clear_logs();
    tick();
    chk("t5_if_valid", 32'(s_if_v), 32'd0);
    chk("t5_if_instr", s_instr, 32'h0000_0013);
    chk("t5_if_pc", s_pc, 32'h0);
    chk("t5_mis", 32'(s_mis), 32'd0);
    repeat (12) tick();
    chk("t5_pop0", qget(pop_pc, 0), 32'h0);
    chk("t5_instr0", qget(pop_instr, 0), 32'hFFFF_FFFF);
    chk("t5_pop1", qget(pop_pc, 1), 32'h4);
    chk("t5_instr1", qget(pop_instr, 1), 32'hFFFF_FFFB);

    // 6: PC wrap
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    clear_logs();
    repeat (14) tick();
    chk("t6_req0", qget(req_log, 0), 32'hFFFF_FFFC);
    chk("t6_req1", qget(req_log, 1), 32'h0);
    chk("t6_pop0", qget(pop_pc, 0), 32'hFFFF_FFFC);
    chk("t6_pc4_0", qget(pop_pc4, 0), 32'h0);
    chk("t6_pop1", qget(pop_pc, 1), 32'h0);
    chk("t6_instr1", qget(pop_instr, 1), 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
